// File: rtl/array_port_serializer.sv
// Array port serializer: captures an NCH-lane frame and emits
// its unmasked lanes one per handshake, in a fixed lane order.
module array_port_serializer #(
  parameter int WIDTH     = 32,
  parameter int NCH       = 2,
  parameter bit LSB_FIRST = 1'b1,
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [NCH],
  input  logic [NCH-1:0]   in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    out_lane,
  output logic             out_last,
  output logic [15:0]      drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] data_d [NCH];
  logic [NCH-1:0]   rem_q, rem_d;
  logic             valid_q, valid_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic [15:0]      drop_q, drop_d;

  logic accept;
  logic take;

  // First pending lane in emission order.
  function automatic logic [LW-1:0] pick(
    input logic [NCH-1:0] m
  );
    logic [LW-1:0] r;
    r = '0;
    if (LSB_FIRST) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (m[i]) r = LW'(i);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m[i]) r = LW'(i);
      end
    end
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign take      = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = odata_q;
  assign out_lane  = lane_q;
  assign out_last  = last_q;
  assign drop_cnt  = drop_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave IDLE on a non-empty frame, return on last lane.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && |in_mask) state_d = SEND;
      SEND: if (take && last_q)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, retire lanes, and precompute the next registered output.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    drop_d = drop_q;
    if (accept) begin
      if (|in_mask) begin
        data_d = in_data;
        rem_d  = in_mask;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (take) begin
      rem_d = rem_q & ~(NCH'(1) << lane_q);
    end
    valid_d = |rem_d;
    lane_d  = valid_d ? pick(rem_d) : lane_q;
    last_d  = valid_d && ((rem_d & (rem_d - NCH'(1))) == '0);
    odata_d = valid_d ? data_d[lane_d] : odata_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '{default: '0};
      rem_q   <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      last_q  <= 1'b0;
      odata_q <= '0;
      drop_q  <= '0;
    end else begin
      data_q  <= data_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      odata_q <= odata_d;
      drop_q  <= drop_d;
    end
  end

endmodule
